// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester round-robin data memory arbiter, 3-cycle IDLE/ACCESS/RESP transaction.
// Define DMEM_ARB_ALIGN_CHECK_EN to reject misaligned (addr[2:0] != 0) accesses with rN_err.
module dmem_arbiter #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              r0_req_i,
   input  logic              r0_we_i,
   input  logic [ADDR_W-1:0] r0_addr_i,
   input  logic [DATA_W-1:0] r0_wdata_i,
   output logic              r0_gnt_o,
   output logic              r0_rvalid_o,
   output logic [DATA_W-1:0] r0_rdata_o,
   output logic              r0_err_o,
   input  logic              r1_req_i,
   input  logic              r1_we_i,
   input  logic [ADDR_W-1:0] r1_addr_i,
   input  logic [DATA_W-1:0] r1_wdata_i,
   output logic              r1_gnt_o,
   output logic              r1_rvalid_o,
   output logic [DATA_W-1:0] r1_rdata_o,
   output logic              r1_err_o,
   output logic              mem_read_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   state_t            state_q, state_d;
   logic              ptr_q, ptr_d, win_q, win_d, we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic              any_req, win, grant, acc, rsp, mis;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
   assign mis = |addr_q[2:0];
`else
   assign mis = 1'b0;
`endif

   // gnt is combinational from req, so it is also masked while reset is held
   assign any_req = r0_req_i | r1_req_i;
   assign win     = (r0_req_i & r1_req_i) ? ptr_q : r1_req_i;
   assign grant   = rst_n & (state_q == IDLE) & any_req;
   assign acc     = state_q == ACCESS;
   assign rsp     = state_q == RESP;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         win_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = (state_q == IDLE) ? (any_req ? ACCESS : IDLE) : (acc ? RESP : IDLE);
      ptr_d   = grant ? ~win : ptr_q;
      win_d   = grant ? win : win_q;
      we_d    = grant ? (win ? r1_we_i : r0_we_i) : we_q;
      addr_d  = grant ? (win ? r1_addr_i : r0_addr_i) : addr_q;
      wdata_d = grant ? (win ? r1_wdata_i : r0_wdata_i) : wdata_q;
      rdata_d = acc ? (mem_read_o ? mem_rdata_i : '0) : rdata_q;
   end

   always_comb begin
      r0_gnt_o    = grant & ~win;
      r1_gnt_o    = grant & win;
      mem_read_o  = acc & ~we_q & ~mis;
      mem_write_o = acc & we_q & ~mis;
      mem_addr_o  = acc ? addr_q : '0;
      mem_wdata_o = acc ? wdata_q : '0;
      r0_rvalid_o = rsp & ~win_q;
      r1_rvalid_o = rsp & win_q;
      r0_err_o    = r0_rvalid_o & mis;
      r1_err_o    = r1_rvalid_o & mis;
      r0_rdata_o  = r0_rvalid_o ? rdata_q : '0;
      r1_rdata_o  = r1_rvalid_o ? rdata_q : '0;
   end
endmodule
